sw_alloc_ctrl: RTL

//  Packet-level (wormhole) switch allocator for one mesh router. Each input port

---
 rtl/sw_alloc_ctrl_pkg.sv | 32 +++
 rtl/sw_alloc_ctrl_rr_arbiter.sv | 34 +++
 rtl/sw_alloc_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/sw_alloc_ctrl_pkg.sv
// Shared port numbering, widths and state types for the wormhole switch allocator.
package sw_alloc_ctrl_pkg;

    localparam int NPORT = 5;
    localparam int PSELW = 3;
    localparam int IDXW  = 3;

    localparam logic [PSELW-1:0] PORT_N = 3'd0;
    localparam logic [PSELW-1:0] PORT_E = 3'd1;
    localparam logic [PSELW-1:0] PORT_S = 3'd2;
    localparam logic [PSELW-1:0] PORT_W = 3'd3;
    localparam logic [PSELW-1:0] PORT_L = 3'd4;

    typedef logic [IDXW-1:0] port_idx_t;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    function automatic port_idx_t onehot_to_idx(input logic [NPORT-1:0] oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) begin
                idx = idx | port_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sw_alloc_ctrl_rr_arbiter.sv
// Round-robin priority search: first requester strictly after ptr, wrapping mod NPORT.
// Latency: purely combinational. Backpressure: none, the caller decides when to use gnt.
// Output gnt is one-hot or zero when no request is present.
module sw_alloc_ctrl_rr_arbiter
    import sw_alloc_ctrl_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  port_idx_t        ptr,
    output logic [NPORT-1:0] gnt
);

    logic [IDXW:0] cand;
    port_idx_t     idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int off = 1; off <= NPORT; off++) begin
            cand = {1'b0, ptr} + (IDXW+1)'(off);
            if (cand >= (IDXW+1)'(NPORT)) begin
                cand = cand - (IDXW+1)'(NPORT);
            end
            idx = cand[IDXW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_alloc_ctrl.sv
// Wormhole switch allocator: per-output round-robin lock held from head to tail flit.
// Latency: head arbitrated in cycle N, first flit moves in N+1; one idle cycle after each tail.
// Backpressure: missing out_rdy or owner in_req inserts a bubble while the lock is kept.
module sw_alloc_ctrl
    import sw_alloc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT-1:0]       in_req,
    input  logic [NPORT-1:0]       in_head,
    input  logic [NPORT-1:0]       in_tail,
    input  logic [NPORT*PSELW-1:0] in_port,
    input  logic [NPORT-1:0]       out_rdy,
    output logic [NPORT-1:0]       grant,
    output logic [NPORT-1:0]       out_valid,
    output logic [NPORT*NPORT-1:0] out_sel,
    output logic                   err_port
);

    out_state_e state_q [NPORT];
    out_state_e state_d [NPORT];
    port_idx_t  owner_q [NPORT];
    port_idx_t  owner_d [NPORT];
    port_idx_t  ptr_q   [NPORT];
    port_idx_t  ptr_d   [NPORT];
    logic       err_q;
    logic       err_d;

    logic [NPORT-1:0][NPORT-1:0] arb_req;
    logic [NPORT-1:0][NPORT-1:0] arb_gnt;
    logic [NPORT-1:0]            owned;
    logic [NPORT-1:0]            bad_head;

    // An input already owning an output is mid-packet; never let it bid for a second one.
    always_comb begin
        owned    = '0;
        arb_req  = '0;
        bad_head = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (state_q[o] == OUT_LOCKED) begin
                owned[owner_q[o]] = 1'b1;
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            bad_head[i] = in_req[i] & in_head[i] &
                          (in_port[i*PSELW +: PSELW] >= PSELW'(NPORT));
            for (int o = 0; o < NPORT; o++) begin
                arb_req[o][i] = in_req[i] & in_head[i] & ~owned[i] &
                                (state_q[o] == OUT_IDLE) &
                                (in_port[i*PSELW +: PSELW] == PSELW'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        sw_alloc_ctrl_rr_arbiter u_arb (
            .req (arb_req[o]),
            .ptr (ptr_q[o]),
            .gnt (arb_gnt[o])
        );
    end

    logic xfer;

    always_comb begin
        grant     = '0;
        out_valid = '0;
        out_sel   = '0;
        xfer      = 1'b0;
        err_d     = err_q | (|bad_head);
        for (int o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            xfer       = 1'b0;
            if (state_q[o] == OUT_LOCKED) begin
                out_sel[o*NPORT +: NPORT] = {{(NPORT-1){1'b0}}, 1'b1} << owner_q[o];
                xfer                      = in_req[owner_q[o]] & out_rdy[o];
                out_valid[o]              = xfer;
                if (xfer) begin
                    grant[owner_q[o]] = 1'b1;
                end
                if (xfer && in_tail[owner_q[o]]) begin
                    state_d[o] = OUT_IDLE;
                    ptr_d[o]   = owner_q[o];
                end
            end else if (|arb_gnt[o]) begin
                state_d[o] = OUT_LOCKED;
                owner_d[o] = onehot_to_idx(arb_gnt[o]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= port_idx_t'(NPORT-1);
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            err_q <= err_d;
        end
    end

    assign err_port = err_q;

endmodule
